// File: rtl/set_job_arbiter_if.sv
// Requester/response channel bundle for set_job_arbiter.
// master = requester/consumer side, slave = arbiter side.
interface set_job_arbiter_if #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = 3
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [24*NREQ-1:0] req_central;
   logic [12*NREQ-1:0] req_radius;
   logic [2*NREQ-1:0]  req_mode;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [7:0]         rsp_candidate;
   logic               rsp_err;

   modport master (
      output req_valid, req_central, req_radius, req_mode, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_candidate, rsp_err
   );

   modport slave (
      input  req_valid, req_central, req_radius, req_mode, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_candidate, rsp_err
   );
endinterface

// File: rtl/set_job_arbiter.sv
// Round-robin job arbiter and watchdog in front of one point-set counting engine.
// Optional per-requester statistics counters are enabled with SET_ARB_STATS_EN.
module set_job_arbiter #(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned IDW     = 3,
   parameter int unsigned TIMEOUT = 512
) (
   input  logic        clk,
   input  logic        rst,
   set_job_arbiter_if.slave bus,
   output logic        set_en,
   output logic [23:0] set_central,
   output logic [11:0] set_radius,
   output logic [1:0]  set_mode,
   input  logic        set_valid,
   input  logic [7:0]  set_candidate
`ifdef SET_ARB_STATS_EN
   ,
   output logic [16*NREQ-1:0] stat_jobs,
   output logic [7:0]         stat_timeouts
`endif
);

   localparam int unsigned WdW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e         state_q, state_d;
   logic [IDW-1:0] last_q, last_d;
   logic [IDW-1:0] id_q, id_d;
   logic [23:0]    cen_q, cen_d;
   logic [11:0]    rad_q, rad_d;
   logic [1:0]     mode_q, mode_d;
   logic [7:0]     cand_q, cand_d;
   logic           err_q, err_d;
   logic [WdW-1:0] wdog_q, wdog_d;

   logic           gnt_found;
   logic [IDW-1:0] gnt_idx;

   // Second pass (indices above last grant) overrides the wrapped first pass.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (bus.req_valid[i] && (i <= int'(last_q))) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'(i);
         end
      end
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (bus.req_valid[i] && (i > int'(last_q))) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'(i);
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      if (state_q == StIdle && gnt_found) begin
         bus.req_ready = NREQ'(1) << gnt_idx;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      cen_d   = cen_q;
      rad_d   = rad_q;
      mode_d  = mode_q;
      cand_d  = cand_q;
      err_d   = err_q;
      wdog_d  = wdog_q;
      unique case (state_q)
         StIdle: begin
            if (gnt_found) begin
               id_d    = gnt_idx;
               cen_d   = bus.req_central[24*gnt_idx +: 24];
               rad_d   = bus.req_radius[12*gnt_idx +: 12];
               mode_d  = bus.req_mode[2*gnt_idx +: 2];
               state_d = StIssue;
            end
         end
         StIssue: begin
            wdog_d  = '0;
            state_d = StWait;
         end
         StWait: begin
            wdog_d = wdog_q + 1'b1;
            if (set_valid) begin
               cand_d  = set_candidate;
               err_d   = 1'b0;
               state_d = StResp;
            end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
               cand_d  = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               last_d  = id_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         last_q  <= IDW'(NREQ - 1);
         id_q    <= '0;
         cen_q   <= '0;
         rad_q   <= '0;
         mode_q  <= '0;
         cand_q  <= '0;
         err_q   <= 1'b0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         cen_q   <= cen_d;
         rad_q   <= rad_d;
         mode_q  <= mode_d;
         cand_q  <= cand_d;
         err_q   <= err_d;
         wdog_q  <= wdog_d;
      end
   end

   assign set_en            = (state_q == StIssue);
   assign set_central       = cen_q;
   assign set_radius        = rad_q;
   assign set_mode          = mode_q;
   assign bus.rsp_valid     = (state_q == StResp);
   assign bus.rsp_id        = id_q;
   assign bus.rsp_candidate = cand_q;
   assign bus.rsp_err       = err_q;

`ifdef SET_ARB_STATS_EN
   logic [15:0] jobs_q [NREQ];
   logic [7:0]  to_q;
   logic        rsp_hs;

   assign rsp_hs = (state_q == StResp) && bus.rsp_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            jobs_q[i] <= '0;
         end
         to_q <= '0;
      end else if (rsp_hs) begin
         if (err_q) begin
            if (to_q != 8'hff) begin
               to_q <= to_q + 1'b1;
            end
         end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
               if (id_q == IDW'(i) && jobs_q[i] != 16'hffff) begin
                  jobs_q[i] <= jobs_q[i] + 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      stat_jobs = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         stat_jobs[16*i +: 16] = jobs_q[i];
      end
   end

   assign stat_timeouts = to_q;
`endif

endmodule

// File: tb/tb_set_job_arbiter.sv
// Randomized self-checking bench for set_job_arbiter against a transaction-level model.
// Connects the statistics ports when SET_ARB_STATS_EN is defined.
module tb_set_job_arbiter;

   localparam int NREQ    = 3;
   localparam int IDW     = 2;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        set_en;
   logic [23:0] set_central;
   logic [11:0] set_radius;
   logic [1:0]  set_mode;
   logic        set_valid;
   logic [7:0]  set_candidate;
`ifdef SET_ARB_STATS_EN
   logic [16*NREQ-1:0] stat_jobs;
   logic [7:0]         stat_timeouts;
`endif

   set_job_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   set_job_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .set_en        (set_en),
      .set_central   (set_central),
      .set_radius    (set_radius),
      .set_mode      (set_mode),
      .set_valid     (set_valid),
      .set_candidate (set_candidate)
`ifdef SET_ARB_STATS_EN
      ,
      .stat_jobs     (stat_jobs),
      .stat_timeouts (stat_timeouts)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: pending requests with their fields, last grant, grant history.
   logic [NREQ-1:0] pend;
   logic [23:0]     p_cen [NREQ];
   logic [11:0]     p_rad [NREQ];
   logic [1:0]      p_mode[NREQ];
   int              last_gnt;
   int              grant_log[$];
   int              exp_jobs[NREQ];
   int              exp_to;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int model_grant();
      for (int k = 1; k <= NREQ; k++) begin
         int i = (last_gnt + k) % NREQ;
         if (pend[i]) return i;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      last_gnt = NREQ - 1;
      pend     = '0;
      exp_to   = 0;
      for (int i = 0; i < NREQ; i++) exp_jobs[i] = 0;
   endfunction

   task automatic new_req(input int i);
      pend[i]   = 1'b1;
      p_cen[i]  = 24'($urandom);
      p_rad[i]  = 12'($urandom);
      p_mode[i] = 2'($urandom);
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i]             = pend[i];
         bus.req_central[24*i +: 24] = p_cen[i];
         bus.req_radius[12*i +: 12]  = p_rad[i];
         bus.req_mode[2*i +: 2]      = p_mode[i];
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      drive_reqs();
      #1;
   endtask

   // Called at a negedge with the DUT idle and requests already driven.
   // n: WAIT cycle in which the engine strobes set_valid (> TIMEOUT means never).
   task automatic run_job(input int n, input int hold, input logic [7:0] cand);
      int g, got, exp_lat;
      logic [23:0] cen;
      logic [11:0] rad;
      logic [1:0]  mode;
      logic        e_err;
      logic [7:0]  e_cand;
      #1;
      g = model_grant();
      if (g < 0) g = 0;
      cen = p_cen[g];
      rad = p_rad[g];
      mode = p_mode[g];
      check_val("req_ready_grant", 32'(bus.req_ready), 32'(1) << g);
      @(posedge clk);
      pend[g] = 1'b0;
      @(negedge clk);
      drive_reqs();
      #1;
      check_val("set_en_issue", 32'(set_en), 1);
      check_val("set_central", 32'(set_central), 32'(cen));
      check_val("set_radius", 32'(set_radius), 32'(rad));
      check_val("set_mode", 32'(set_mode), 32'(mode));
      check_val("req_ready_busy", 32'(bus.req_ready), 0);
      @(posedge clk);
      @(negedge clk);
      got = 0;
      for (int c = 1; c <= TIMEOUT + 4; c++) begin
         if (bus.rsp_valid) begin
            got = c;
            break;
         end
         set_valid     = (c == n);
         set_candidate = (c == n) ? cand : 8'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      set_valid = 1'b0;
      exp_lat = ((n < TIMEOUT) ? n : TIMEOUT) + 1;
      check_val("rsp_latency", 32'(got), 32'(exp_lat));
      e_err  = (n > TIMEOUT);
      e_cand = e_err ? 8'h00 : cand;
      for (int h = 0; h <= hold; h++) begin
         check_val("rsp_valid", 32'(bus.rsp_valid), 1);
         check_val("rsp_id", 32'(bus.rsp_id), 32'(g));
         check_val("rsp_candidate", 32'(bus.rsp_candidate), 32'(e_cand));
         check_val("rsp_err", 32'(bus.rsp_err), 32'(e_err));
         check_val("req_ready_resp", 32'(bus.req_ready), 0);
         bus.rsp_ready = (h == hold);
         if (h < hold) begin
            set_valid     = 1'($urandom);
            set_candidate = 8'($urandom);
         end
         @(posedge clk);
         @(negedge clk);
         set_valid = 1'b0;
      end
      bus.rsp_ready = 1'b0;
      check_val("rsp_valid_drop", 32'(bus.rsp_valid), 0);
      last_gnt = g;
      grant_log.push_back(g);
      if (e_err) exp_to = (exp_to < 255) ? exp_to + 1 : 255;
      else exp_jobs[g] = (exp_jobs[g] < 65535) ? exp_jobs[g] + 1 : 65535;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      int base;
      rst = 1'b0;
      set_valid = 1'b0;
      set_candidate = '0;
      bus.req_valid = '0;
      bus.req_central = '0;
      bus.req_radius = '0;
      bus.req_mode = '0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         p_cen[i] = '0;
         p_rad[i] = '0;
         p_mode[i] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      do_reset();
      check_val("rst_set_en", 32'(set_en), 0);
      check_val("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check_val("rst_req_ready", 32'(bus.req_ready), 0);
      check_val("rst_rsp_id", 32'(bus.rsp_id), 0);
      check_val("rst_rsp_cand", 32'(bus.rsp_candidate), 0);
      check_val("rst_rsp_err", 32'(bus.rsp_err), 0);
      check_val("rst_set_central", 32'(set_central), 0);

      // Single job on requester 0.
      pend[0] = 1'b1;
      p_cen[0] = 24'h440000;
      p_rad[0] = 12'h200;
      p_mode[0] = 2'd0;
      drive_reqs();
      run_job(7, 0, 8'd13);

      // Simultaneous requests after reset, then alternation while both hold.
      do_reset();
      base = grant_log.size();
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 2; i++) if (!pend[i]) new_req(i);
         drive_reqs();
         run_job($urandom_range(1, 8), 0, 8'($urandom));
      end
      for (int k = 0; k < 4; k++) check_val("fair_seq", 32'(grant_log[base+k]), 32'(k % 2));

      // Timeout with a late strobe during backpressure.
      pend = '0;
      new_req(1);
      drive_reqs();
      run_job(TIMEOUT + 4, 5, 8'h5a);

      // Random traffic.
      for (int j = 0; j < 60; j++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
            else if (pend[i] && $urandom_range(0, 7) == 0) pend[i] = 1'b0;
         end
         if (pend == '0) begin
            drive_reqs();
            #1;
            check_val("idle_req_ready", 32'(bus.req_ready), 0);
            check_val("idle_set_en", 32'(set_en), 0);
            @(posedge clk);
            @(negedge clk);
            new_req($urandom_range(0, NREQ - 1));
         end
         drive_reqs();
         run_job($urandom_range(1, TIMEOUT + 4), $urandom_range(0, 4), 8'($urandom));
      end

`ifdef SET_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) begin
         check_val("stat_jobs", 32'(stat_jobs[16*i +: 16]), 32'(exp_jobs[i]));
      end
      check_val("stat_timeouts", 32'(stat_timeouts), 32'(exp_to));
`endif

      // Reset while the engine is busy.
      pend = '0;
      new_req(1);
      drive_reqs();
      @(posedge clk);
      pend[1] = 1'b0;
      @(negedge clk);
      drive_reqs();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      check_val("mid_rst_set_en", 32'(set_en), 0);
      check_val("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check_val("mid_rst_req_ready", 32'(bus.req_ready), 0);
      for (int i = 0; i < NREQ; i++) new_req(i);
      drive_reqs();
      run_job(4, 1, 8'($urandom));
      check_val("mid_rst_grant", 32'(grant_log[grant_log.size()-1]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/set_job_arbiter.md
Name: set_job_arbiter

Overview:
- Front-end controller for one point-set counting engine (en/central/radius/mode in; valid/candidate out).
- Accepts counting jobs from NREQ independent requesters and arbitrates them round-robin.
- Issues one job at a time to the engine, waits for completion and returns the tagged result on a single shared response channel.
- A watchdog turns a hung engine into an error response.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, 3, width of rsp_id (must satisfy 2^IDW >= NREQ).
- TIMEOUT, 512, max cycles in WAIT before an error response; must exceed engine job latency (about 260 cycles).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  NREQ  job request per requester.
- req_ready  out  NREQ  job accepted this cycle (one-hot or zero).
- req_central  in  24*NREQ  per-requester centers {x1,y1,x2,y2,x3,y3}, 4 bits each; slice i = bits [24i+23:24i].
- req_radius  in  12*NREQ  per-requester {r1,r2,r3}.
- req_mode  in  2*NREQ  per-requester set-operation mode.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_candidate  out  8  engine count.
- rsp_err  out  1  job timed out.
- set_en  out  1  one-cycle engine start pulse.
- set_central  out  24  to engine.
- set_radius  out  12  to engine.
- set_mode  out  2  to engine.
- set_valid  in  1  engine result strobe.
- set_candidate  in  8  engine count, sampled when set_valid=1.

Behaviour:
- Reset (rst=0 at an edge):
  - All outputs go to 0; FSM goes to IDLE; watchdog counter goes to 0.
  - last_grant = NREQ-1, so requester 0 has top priority after reset.
  - Reset in any state aborts the job in flight without a response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - g = first i with req_valid[i]=1, searching from last_grant+1 upward with wrap-around.
  - req_ready[g] is driven combinationally high in IDLE only.
  - On the accept (req_valid & req_ready), register that requester's central, radius and mode plus id g, then go to ISSUE.
  - No request pending: stay in IDLE.
- ISSUE:
  - set_en=1 for exactly this one cycle.
  - set_central/radius/mode hold the registered job from ISSUE until the FSM leaves RESP.
  - Next state: WAIT; watchdog cleared.
- WAIT:
  - Watchdog increments each cycle.
  - set_valid=1: capture set_candidate, set err=0, go to RESP.
  - Else, watchdog == TIMEOUT-1: candidate=0, err=1, go to RESP.
  - set_valid wins if both occur in the same cycle.
- RESP:
  - rsp_valid=1; rsp_id, rsp_candidate and rsp_err held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready: last_grant = id, go to IDLE; rsp_valid falls at the next edge.
- set_valid outside WAIT (late result after a timeout) is ignored.
- req_ready stays 0 outside IDLE.
- Latency:
  - accept to set_en: 1 cycle.
  - set_valid to rsp_valid: 1 cycle.
  - rsp handshake to next possible accept: 1 cycle.
- Requester obligations: hold req_valid and its fields stable until accepted. Deasserting req_valid before acceptance withdraws the request and is legal.
- Engine status flags are not used for sequencing; completion is set_valid only.

Optional Feature:
- Macro SET_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_jobs (16*NREQ): per-requester completed-job counters, incremented on each response handshake whose err=0.
  - Adds stat_timeouts (8): incremented on each err=1 handshake.
  - All counters saturate at their maximum and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single job: engine model; requester 0, central=24'h440000, radius=12'h200, mode=0 -> set_en one cycle after accept; rsp_valid with rsp_id=0, rsp_candidate=13, rsp_err=0.
- Post-reset simultaneous requests: req_valid=2'b11 -> first grant to requester 0, then requester 1; response ids in order 0,1.
- Fairness: both requesters hold req_valid high for 4 jobs -> grant sequence 0,1,0,1; no back-to-back grant to the same requester while the other waits.
- Timeout: TIMEOUT=16, engine never asserts set_valid -> rsp_valid 17 cycles after set_en with rsp_err=1, rsp_candidate=0; a set_valid 5 cycles later is ignored.
- Backpressure: rsp_ready=0 for 5 cycles while req_valid[1]=1 -> rsp fields stable, req_ready=0 throughout, grant 1 cycle after the handshake.
- Reset mid-WAIT: rst=0 for one edge -> set_en, rsp_valid and req_ready all 0; next job granted to requester 0 and completes normally.
